// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity and stop-bit constants.
// Shared by the transmitter and the future receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam logic ParityEven = 1'b0;
  localparam logic ParityOdd  = 1'b1;

  localparam logic StopOne = 1'b0;
  localparam logic StopTwo = 1'b1;

  // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_serialiser_if.sv
// Upstream word handshake for the UART transmitter, with per-word frame settings.
// Parity settings exist only when UART_TX_PARITY_EN is defined.
interface uart_tx_serialiser_if #(
  parameter int unsigned W_DATA = 8
);

  logic              s_valid;
  logic [W_DATA-1:0] s_data;
  logic              s_ready;
  logic              two_stop;
`ifdef UART_TX_PARITY_EN
  logic              parity_en;
  logic              parity_odd;
`endif

`ifdef UART_TX_PARITY_EN
  modport master (
    output s_valid, s_data, two_stop, parity_en, parity_odd,
    input  s_ready
  );

  modport slave (
    input  s_valid, s_data, two_stop, parity_en, parity_odd,
    output s_ready
  );
`else
  modport master (
    output s_valid, s_data, two_stop,
    input  s_ready
  );

  modport slave (
    input  s_valid, s_data, two_stop,
    output s_ready
  );
`endif

endinterface

// File: rtl/uart_bit_timer.sv
// Counts tick strobes within one bit period; bit_done marks the OVERSAMPLE-th tick.
module uart_bit_timer #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic tick,
  output logic bit_done
);

  localparam int unsigned W_CNT = $clog2(OVERSAMPLE);
  localparam logic [W_CNT-1:0] LastTick = W_CNT'(OVERSAMPLE - 1);

  logic [W_CNT-1:0] cnt_q;

  // clr wins over tick so a tick coinciding with word acceptance is not counted.
  assign bit_done = tick && !clr && (cnt_q == LastTick);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= bit_done ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_serialiser.sv
// UART transmitter: start bit, W_DATA bits LSB-first, optional parity, one or two stop bits.
// Define UART_TX_PARITY_EN to add the parity bit and its per-word settings.
module uart_tx_serialiser
  import uart_pkg::*;
#(
  parameter int unsigned W_DATA     = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                tick,
  uart_tx_serialiser_if.slave s_if,
  output logic                tx,
  output logic                busy
);

  localparam int unsigned W_BCNT = $clog2(W_DATA);
  localparam logic [W_BCNT-1:0] LastBit = W_BCNT'(W_DATA - 1);

  uart_state_e       state_q;
  logic [W_DATA-1:0] shift_q;
  logic [W_BCNT-1:0] bit_cnt_q;
  logic              two_stop_q;
  logic              stop_cnt_q;
`ifdef UART_TX_PARITY_EN
  logic              parity_en_q;
  logic              parity_q;
`endif

  logic xfer;
  logic timer_clr;
  logic bit_done;

  assign s_if.s_ready = en && (state_q == StIdle);
  assign xfer         = s_if.s_valid && s_if.s_ready;
  assign timer_clr    = !en || (state_q == StIdle);

  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .tick    (tick),
    .bit_done(bit_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tx          <= 1'b1;
      busy        <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      two_stop_q  <= StopOne;
      stop_cnt_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_en_q <= 1'b0;
      parity_q    <= 1'b0;
`endif
    end else if (!en) begin
      // Abort: drop the latched word and park the line idle.
      state_q     <= StIdle;
      tx          <= 1'b1;
      busy        <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (xfer) begin
            state_q     <= StStart;
            tx          <= 1'b0;
            busy        <= 1'b1;
            shift_q     <= s_if.s_data;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            two_stop_q  <= s_if.two_stop;
`ifdef UART_TX_PARITY_EN
            parity_en_q <= s_if.parity_en;
            parity_q    <= parity_bit(9'(s_if.s_data), s_if.parity_odd);
`endif
          end
        end
        StStart: begin
          if (bit_done) begin
            state_q <= StData;
            tx      <= shift_q[0];
          end
        end
        StData: begin
          if (bit_done) begin
            shift_q <= shift_q >> 1;
            if (bit_cnt_q == LastBit) begin
              bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
              if (parity_en_q) begin
                state_q <= StParity;
                tx      <= parity_q;
              end else begin
                state_q <= StStop;
                tx      <= 1'b1;
              end
`else
              state_q <= StStop;
              tx      <= 1'b1;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              tx        <= shift_q[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (bit_done) begin
            state_q <= StStop;
            tx      <= 1'b1;
          end
        end
`endif
        StStop: begin
          if (bit_done) begin
            if (two_stop_q && !stop_cnt_q) begin
              stop_cnt_q <= 1'b1;
            end else begin
              state_q    <= StIdle;
              busy       <= 1'b0;
              stop_cnt_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          tx      <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
